imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Pipelined, multi-mode immediate generator for the decode stage of the MIPS core. It replaces the single-bit zero/sign extender with a mode-selected generator: zero, sign, LUI, shift-amount, branch-offset and jump-target forms. Results pass through a parametrised register pipeline with valid/ready handshaking, so decode can stall or flush without losing or duplicating immediates. It sits between instruction-field extraction and the ID/EX operand muxes.

## Interface
Parameters:
- DATA_W, default 32: output width; legal values are 32 or greater.
- STAGES, default 1: number of pipeline register stages; legal values are 1 to 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discards every in-flight entry on the next edge.
- in_valid  input  1  the input beat is valid.
- in_ready  output  1  the block accepts the beat this cycle.
- in_mode  input  3  extension mode; encodings are listed under Operation.
- in_field  input  26  instruction bits [25:0]; imm16 is in_field[15:0].
- in_pc  input  DATA_W  PC+4 of the instruction, used by JUMP mode.
- in_tag  input  8  opaque tag, carried through unchanged.
- out_valid  output  1  the output beat is valid.
- out_ready  input  1  the consumer accepts the beat.
- out_data  output  DATA_W  generated immediate.
- out_tag  output  8  tag of the output beat.
- out_err  output  1  the beat used a reserved mode.

## Operation
Mode encodings, evaluated combinationally on the input beat:
- 0 ZERO: imm16 zero-extended to DATA_W.
- 1 SIGN: imm16 sign-extended using bit 15.
- 2 LUI: {imm16, 16'b0}, with the upper DATA_W-32 bits sign-extended from bit 31.
- 3 SHAMT: in_field[10:6] zero-extended.
- 4 BRANCH: sign-extended imm16 shifted left by 2. Bits shifted out above DATA_W are discarded.
- 5 JUMP: {in_pc[DATA_W-1:28], in_field[25:0], 2'b00}.
- 6 and 7 are reserved: out_data = 0 and out_err = 1.

Pipeline:
- STAGES entries. Each entry holds valid, data, tag and err.
- Entry k loads from entry k-1, or from the input when k = 0, whenever entry k is empty or entry k will itself advance this cycle.
- Bubbles collapse: an empty middle stage does not block upstream entries.
- in_ready = !stage0.valid | stage0_advances. The chain is combinational back to out_ready. There is no skid buffer.
- Outputs come from the last entry. A beat transfers when out_valid & out_ready.
- Order is strictly preserved. Each accepted beat appears exactly once.

Flush:
- When flush = 1, every valid bit clears at the next edge.
- An input beat presented in the same cycle is dropped, even if in_ready was high.
- A beat that is transferring on the output in the same cycle counts as delivered.

Reset:
- All valid bits = 0, so out_valid = 0.
- out_data = 0, out_tag = 0, out_err = 0.
- in_ready reads 1 in the first cycle after reset is released.
- A reset asserted mid-stream clears all entries in one edge. rst has priority over flush.

## Timing
- Latency is STAGES cycles from an accepted input to out_valid, with no backpressure.
- Throughput is one beat per cycle while out_ready = 1.
- If out_ready is held low, the block fills after STAGES accepted beats. in_ready then drops in the same cycle the last entry fills.
- When out_ready rises, in_ready rises combinationally in that same cycle. There are no lost cycles.
- While out_valid = 1 and out_ready = 0, out_data, out_tag and out_err hold stable.
- No path through the block exists from in_* to out_*. The only combinational path is out_ready to in_ready.

## Test plan
- Mode sweep, STAGES=1, imm16 = 16'h8004:
  - ZERO gives 32'h00008004.
  - SIGN gives 32'hFFFF8004.
  - LUI gives 32'h80040000.
  - BRANCH gives 32'hFFFE0010.
  - SHAMT with in_field[10:6] = 5'd31 gives 32'h0000001F.
  - JUMP with in_pc = 32'hA0000000 and in_field = 26'h3FFFFFF gives 32'hAFFFFFFC.
- Reserved mode 6 with in_tag = 8'h5A: out_data = 0, out_err = 1, out_tag = 8'h5A.
- STAGES=3, out_ready held 0, stream tags 1..5:
  - Exactly 3 beats are accepted, and in_ready = 0 after the third.
  - Releasing out_ready yields tags 1..5 in order, one per cycle.
- STAGES=2, continuous valid with out_ready toggling every cycle: no tag is dropped or duplicated, and output values stay stable while stalled.
- Flush with 2 entries held and in_valid = 1 in the flush cycle: the next cycle has out_valid = 0. The following beats resume with first-beat latency equal to STAGES.
- rst asserted while full: the next cycle has out_valid = 0, out_data = 0 and in_ready = 1. DATA_W = 64 with SIGN mode and imm16 = 16'hFFFF gives 64'hFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator with a STAGES-deep valid/ready register pipeline.
// Mode selects zero/sign/LUI/shamt/branch/jump forms; modes 6 and 7 flag out_err.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [25:0]       in_field,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [7:0]        in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_tag,
  output logic              out_err
);

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_SIGN   = 3'd1,
    MODE_LUI    = 3'd2,
    MODE_SHAMT  = 3'd3,
    MODE_BRANCH = 3'd4,
    MODE_JUMP   = 3'd5
  } mode_t;

  logic [15:0]       imm16;
  logic [31:0]       lui32;
  logic [DATA_W-1:0] gen_data;
  logic              gen_err;

  assign imm16 = in_field[15:0];
  assign lui32 = {imm16, 16'b0};

  always_comb begin
    gen_data = '0;
    gen_err  = 1'b0;
    case (in_mode)
      MODE_ZERO: gen_data[15:0] = imm16;
      MODE_SIGN: begin
        gen_data       = {DATA_W{imm16[15]}};
        gen_data[15:0] = imm16;
      end
      MODE_LUI: begin
        gen_data       = {DATA_W{lui32[31]}};
        gen_data[31:0] = lui32;
      end
      MODE_SHAMT: gen_data[4:0] = in_field[10:6];
      MODE_BRANCH: begin
        gen_data       = {DATA_W{imm16[15]}};
        gen_data[17:0] = {imm16, 2'b00};
      end
      MODE_JUMP: begin
        gen_data       = in_pc;
        gen_data[27:0] = {in_field, 2'b00};
      end
      default: gen_err = 1'b1;
    endcase
  end

  logic [STAGES-1:0] vld;
  logic [DATA_W-1:0] dat [STAGES];
  logic [7:0]        tag [STAGES];
  logic [STAGES-1:0] err;

  // ld[k]: entry k may load this edge (empty, or its contents move on).
  // ld[STAGES] is the consumer side, so the chain reaches back to out_ready.
  logic [STAGES:0]   ld;
  logic [STAGES-1:0] src_vld;
  logic [DATA_W-1:0] src_dat [STAGES];
  logic [7:0]        src_tag [STAGES];
  logic [STAGES-1:0] src_err;

  always_comb begin
    ld         = '0;
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld[k] | ld[k+1];
    end
  end

  always_comb begin
    src_vld    = '0;
    src_err    = '0;
    src_vld[0] = in_valid;
    src_dat[0] = gen_data;
    src_tag[0] = in_tag;
    src_err[0] = gen_err;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld[k-1];
      src_dat[k] = dat[k-1];
      src_tag[k] = tag[k-1];
      src_err[k] = err[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      err <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
        tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= src_vld[k] & !flush;
          if (src_vld[k]) begin
            dat[k] <= src_dat[k];
            tag[k] <= src_tag[k];
            err[k] <= src_err[k];
          end
        end else if (flush) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];
  assign out_tag   = tag[STAGES-1];
  assign out_err   = err[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: four instances (1/2/3 stages, 64-bit) share stimulus;
// each section checks the instance whose depth or width it targets.
module tb_imm_extend_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  in_mode;
  logic [25:0] in_field;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;
  logic [7:0]  in_tag;

  logic r1, v1, e1, r2, v2, e2, r3, v3, e3, r64, v64, e64;
  logic [31:0] d1, d2, d3;
  logic [63:0] d64;
  logic [7:0]  t1, t2, t3, t64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  assign in_pc64 = {32'h0, in_pc};

  imm_extend_pipe #(.DATA_W(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_mode(in_mode), .in_field(in_field), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_tag(t1), .out_err(e1));
  imm_extend_pipe #(.DATA_W(32), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r2),
    .in_mode(in_mode), .in_field(in_field), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_tag(t2), .out_err(e2));
  imm_extend_pipe #(.DATA_W(32), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r3),
    .in_mode(in_mode), .in_field(in_field), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(v3), .out_ready(out_ready), .out_data(d3), .out_tag(t3), .out_err(e3));
  imm_extend_pipe #(.DATA_W(64), .STAGES(1)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_mode(in_mode), .in_field(in_field), .in_pc(in_pc64), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_data(d64), .out_tag(t64), .out_err(e64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 3'd0; in_field = '0; in_pc = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [25:0] field;
    logic [31:0] pc;
    logic [7:0]  tag;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  vec_t vt [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, first, last, cyc, lat2, lat3, expt;
    logic accept, held;
    logic [7:0]  htag;
    logic [31:0] hdat;

    vt[0]  = '{3'd0, 26'h0008004, 32'h0,        8'h01, 32'h00008004, 64'h0000000000008004, 1'b0};
    vt[1]  = '{3'd1, 26'h0008004, 32'h0,        8'h02, 32'hFFFF8004, 64'hFFFFFFFFFFFF8004, 1'b0};
    vt[2]  = '{3'd2, 26'h0008004, 32'h0,        8'h03, 32'h80040000, 64'hFFFFFFFF80040000, 1'b0};
    vt[3]  = '{3'd4, 26'h0008004, 32'h0,        8'h04, 32'hFFFE0010, 64'hFFFFFFFFFFFE0010, 1'b0};
    vt[4]  = '{3'd3, 26'h00007C0, 32'h0,        8'h05, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[5]  = '{3'd5, 26'h3FFFFFF, 32'hA0000000, 8'h06, 32'hAFFFFFFC, 64'h00000000AFFFFFFC, 1'b0};
    vt[6]  = '{3'd6, 26'h0008004, 32'h0,        8'h5A, 32'h00000000, 64'h0,                1'b1};
    vt[7]  = '{3'd7, 26'h3FFFFFF, 32'hFFFFFFFF, 8'h07, 32'h00000000, 64'h0,                1'b1};
    vt[8]  = '{3'd1, 26'h000FFFF, 32'h0,        8'h08, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[9]  = '{3'd4, 26'h0000001, 32'h0,        8'h09, 32'h00000004, 64'h0000000000000004, 1'b0};
    vt[10] = '{3'd2, 26'h0001234, 32'h0,        8'h0A, 32'h12340000, 64'h0000000012340000, 1'b0};
    vt[11] = '{3'd0, 26'h3FFFFFF, 32'h0,        8'h0B, 32'h0000FFFF, 64'h000000000000FFFF, 1'b0};
    vt[12] = '{3'd3, 26'h3FFF83F, 32'h0,        8'h0C, 32'h00000000, 64'h0,                1'b0};
    vt[13] = '{3'd5, 26'h0000001, 32'h5FFFFFF0, 8'h0D, 32'h50000004, 64'h0000000050000004, 1'b0};

    do_reset();
    chk("reset_valid", v1, 1'b0);
    chk("reset_data", d1, 32'h0);
    chk("reset_tag", t1, 8'h0);
    chk("reset_err", e1, 1'b0);
    chk("reset_ready", r3, 1'b1);

    // mode sweep, one beat per cycle through the single-stage and 64-bit instances
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_mode = vt[i].mode; in_field = vt[i].field;
      in_pc = vt[i].pc; in_tag = vt[i].tag;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), v1, 1'b1);
      chk($sformatf("v%0d_data", i), d1, vt[i].exp32);
      chk($sformatf("v%0d_err", i), e1, vt[i].err);
      chk($sformatf("v%0d_tag", i), t1, vt[i].tag);
      chk($sformatf("v%0d_data64", i), d64, vt[i].exp64);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // STAGES=3 fill with out_ready low, then drain in order
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0; in_tag = 8'd1; in_field = 26'd1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      accept = r3;
      if (accept) acc++;
      @(posedge clk); #1;
      if (accept) begin in_tag = in_tag + 8'd1; in_field = 26'(in_tag); end
    end
    chk("s3_accepted", acc, 3);
    chk("s3_full_ready", r3, 1'b0);
    chk("s3_head_tag", t3, 8'd1);
    out_ready = 1'b1;
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("s3_ready_comb", r3, 1'b1);
      accept = r3 & in_valid;
      if (v3) begin
        chk($sformatf("s3_drain%0d", got), t3, 8'(got + 1));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk); #1;
      if (accept) begin
        in_tag = in_tag + 8'd1; in_field = 26'(in_tag);
        if (in_tag > 8'd5) in_valid = 1'b0;
      end
    end
    chk("s3_drain_count", got, 5);
    chk("s3_drain_span", last - first, 4);
    in_valid = 1'b0;

    // STAGES=2 with out_ready toggling every cycle
    do_reset();
    in_valid = 1'b1; in_mode = 3'd0; in_tag = 8'd1; in_field = 26'd1;
    expt = 1; held = 1'b0; htag = '0; hdat = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      out_ready = c[0];
      #1;
      if (held) begin
        chk("s2_hold_tag", t2, htag);
        chk("s2_hold_data", d2, hdat);
      end
      if (v2 && out_ready) begin
        chk("s2_tag", t2, 8'(expt));
        chk("s2_data", d2, 32'(expt));
        expt++;
      end
      held = v2 & !out_ready; htag = t2; hdat = d2;
      accept = r2;
      @(posedge clk); #1;
      if (accept) begin in_tag = in_tag + 8'd1; in_field = 26'(in_tag); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (v2) begin
        chk("s2_drain_tag", t2, 8'(expt));
        expt++;
      end
    end
    chk("s2_all_delivered", expt, int'(in_tag));

    // flush with two entries held in STAGES=2 and a beat offered in the flush cycle
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0; in_tag = 8'd10; in_field = 26'd10;
    acc = 0;
    for (int c = 0; c < 5 && acc < 2; c++) begin
      @(negedge clk);
      accept = r2;
      @(posedge clk); #1;
      if (accept) begin acc++; in_tag = in_tag + 8'd1; in_field = 26'(in_tag); end
    end
    chk("fl_filled", acc, 2);
    flush = 1'b1; in_tag = 8'd12; in_field = 26'd12;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid2", v2, 1'b0);
    chk("fl_valid3", v3, 1'b0);
    chk("fl_ready2", r2, 1'b1);
    in_tag = 8'd13; in_field = 26'd13; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat2 = -1; lat3 = -1; cyc = 1;
    for (int c = 0; c < 8; c++) begin
      if (v2 && lat2 < 0) begin lat2 = cyc; chk("fl_tag2", t2, 8'd13); end
      if (v3 && lat3 < 0) begin lat3 = cyc; chk("fl_tag3", t3, 8'd13); end
      @(posedge clk); #1;
      cyc++;
    end
    chk("fl_latency2", lat2, 2);
    chk("fl_latency3", lat3, 3);

    // reset (with flush also high) while STAGES=3 is full
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 8'h77; in_field = 26'h0FFFF;
    repeat (4) @(posedge clk);
    #1;
    chk("rf_full_ready", r3, 1'b0);
    chk("rf_full_valid", v3, 1'b1);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("rf_valid", v3, 1'b0);
    chk("rf_data", d3, 32'h0);
    chk("rf_tag", t3, 8'h0);
    chk("rf_ready", r3, 1'b1);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rf_after_ready", r3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
